// File: rtl/nested_cnt_pkg.sv
// Shared types and sizing helpers for the nested-count receiver.
package nested_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic {
        RESTART = 1'b0,
        ACCUM   = 1'b1
    } mode_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nested_idx_cnt.sv
// Inner/outer beat index counters with wrap and a last-beat flag.
module nested_idx_cnt
    import nested_cnt_pkg::*;
#(
    parameter int INNER = 3,
    parameter int OUTER = 3,
    parameter int IW    = cnt_w(OUTER),
    parameter int JW    = cnt_w(INNER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] I_MAX = IW'(OUTER - 1);
    localparam logic [JW-1:0] J_MAX = JW'(INNER - 1);

    assign last = (i == I_MAX) && (j == J_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
        end else if (inc) begin
            if (j == J_MAX) begin
                j <= '0;
                i <= (i == I_MAX) ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nested_cnt_rx.sv
// Checks a nested-loop count stream (RESTART or ACCUM) beat by beat.
// Optional NESTED_CNT_RX_HALT_ON_ERR_EN: freeze in HALT on the first mismatch.
module nested_cnt_rx
    import nested_cnt_pkg::*;
#(
    parameter int W     = 8,
    parameter int INNER = 3,
    parameter int OUTER = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] exp_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] err_cnt
);

    localparam int IW = cnt_w(OUTER);
    localparam int JW = cnt_w(INNER);
    localparam logic [JW-1:0] J_MAX = JW'(INNER - 1);

`ifdef NESTED_CNT_RX_HALT_ON_ERR_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_e        state;
    mode_e         mode_q;
    logic [IW-1:0] cnt_i;
    logic [JW-1:0] cnt_j;
    logic          last;
    logic          launch;
    logic          accept;
    logic          mismatch;
    logic          halting;
    logic [W-1:0]  exp_now;
    logic [W-1:0]  exp_nxt;

    assign launch   = (state == IDLE) && start;
    assign accept   = (state == RUN) && in_valid && in_ready;
    assign exp_now  = (mode_q == ACCUM)
                    ? W'(32'(cnt_i) * 32'(INNER) + 32'(cnt_j) + 32'd1)
                    : W'(32'(cnt_j) + 32'd1);
    // ACCUM is a linear index, so the next expectation is simply +1.
    assign exp_nxt  = (mode_q == RESTART && cnt_j == J_MAX) ? W'(1) : exp_now + 1'b1;
    assign mismatch = accept && (in_data != exp_now);
    assign halting  = HALT_EN && mismatch;

    nested_idx_cnt #(
        .INNER (INNER),
        .OUTER (OUTER),
        .IW    (IW),
        .JW    (JW)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept && !halting),
        .clr   (launch),
        .i     (cnt_i),
        .j     (cnt_j),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= RESTART;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            exp_data <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        mode_q   <= mode_e'(mode);
                        err_cnt  <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        exp_data <= W'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (halting) begin
                            state    <= HALT;
                            in_ready <= 1'b0;
                        end else if (last) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            exp_data <= exp_nxt;
                        end
                    end
                end
                // Only reset leaves HALT.
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
